output_ram_ctrl: RTL and testbench
==================================

Name: output_ram_ctrl

Overview:
Write sequencer for the output result RAM. It takes 2N-bit results from the datapath over a valid/ready handshake and drives the RAM's clr/outRAMen/addr/result/done controls. It clears the RAM's dump file at job start, writes exactly M results to 1-based addresses 1..M, and pulses done once the last write has been committed. It sits between the compute datapath and the output RAM, one instance per RAM.

Parameters:
N, 16, half result width; result buses are 2N bits
M, 8, number of results per job (RAM depth)
K, 3, address MSB index; addr is K+1 bits; M <= 2^(K+1)-1 required

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  begin a job; sampled only in IDLE
res_valid  in  1  datapath presents result_in
res_ready  out  1  controller accepts result_in this cycle
result_in  in  2N  result from datapath
result  out  2N  registered data to RAM
addr  out  K+1  registered 1-based RAM address (RAM writes addr-1)
outRAMen  out  1  RAM write enable, one cycle per result
clr  out  1  one-cycle RAM/file clear pulse
done  out  1  one-cycle job-complete pulse
busy  out  1  high from CLEAR through FIN inclusive

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, count=0; result, addr, outRAMen, clr, done, res_ready all 0; busy=0. Applies mid-job: the job is abandoned and no done is issued.
- All outputs are registered or decoded from the state register only; res_ready does not depend combinationally on res_valid.
- States: IDLE, CLEAR, WRITE, DRAIN, FIN.
- IDLE: res_ready=0. start=1 -> CLEAR.
- CLEAR: lasts one cycle. clr=1, count<=0 -> WRITE.
- WRITE: res_ready=1. Accept = res_valid & res_ready in cycle t.
  - On accept: next cycle result<=result_in, addr<=count+1, outRAMen=1, count<=count+1. Latency is 1 cycle.
  - Without an accept, outRAMen=0 next cycle and addr/result hold.
  - When the accept brings count to M: -> DRAIN.
- DRAIN: outRAMen=1 for the M-th write, res_ready=0 -> FIN.
- FIN: done=1 for one cycle, strictly after the last outRAMen, because the RAM gives outRAMen priority over done -> IDLE.
- Back-to-back accepts are allowed: M results can arrive in M consecutive cycles. Minimum job length is M+3 cycles from start.
- start outside IDLE is ignored.
- res_valid outside WRITE is ignored and the data is dropped; res_ready=0 there.
- count width is K+1; count never exceeds M. addr takes values 1..M only and never 0 during outRAMen.
- clr and outRAMen are never high in the same cycle. done and outRAMen are never high in the same cycle.

Optional Feature:
OUTCTRL_ERR_EN
- Defined: adds output err (1 bit), a sticky flag.
  - Set when res_valid=1 in any state other than WRITE while busy=1.
  - Set when start=1 while busy=1.
  - Cleared only by rst or by entering CLEAR.
- Undefined: no err port or logic. All other behaviour is identical.

Decomposition:
- Shared package (outctrl_pkg): state encoding constants (IDLE=0, CLEAR=1, WRITE=2, DRAIN=3, FIN=4, 3-bit) and the default N/M/K values.
- One natural sub-module, output_addr_counter: a (K+1)-bit counter with sync clear, increment enable, and a terminal flag (count==M-1 on increment).
- The FSM and output registers stay in the top module.

Test Plan:
- rst then start, 8 results 0x00000001..0x00000008 on consecutive cycles -> clr one cycle, then outRAMen on 8 consecutive cycles with addr 1..8 and matching result, done once at 2 cycles after the last accept, busy low after.
- res_valid toggled 1,0,1,0 during WRITE -> outRAMen only in cycles following accepts, addr contiguous 1..8, no gaps in addresses.
- start held high throughout a job -> exactly one job, one clr and one done; with OUTCTRL_ERR_EN, err=1 after the second cycle of busy.
- rst asserted after 3 writes -> next cycle all outputs 0, no done. New start -> clr again, addr restarts at 1.
- res_valid=1 with result_in=0xDEADBEEF while IDLE -> res_ready=0, no outRAMen, subsequent job unaffected.
- M=1 parameter override -> clr, one outRAMen with addr=1, done in the following cycle's successor, never concurrent with outRAMen.

Source files
------------

// File: rtl/outctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : outctrl_pkg
// Purpose  : Shared state encoding and default sizing for the output RAM
//            write sequencer (output_ram_ctrl) and its address counter.
// Revision : 1.0 - initial release
// ============================================================================
package outctrl_pkg;

  // Default sizing: result buses are 2*C_N bits, C_M results per job,
  // address is C_K+1 bits wide.
  localparam int C_N = 16;
  localparam int C_M = 8;
  localparam int C_K = 3;

  // Sequencer states, fixed 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_WRITE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage : outctrl_pkg
`default_nettype wire

// File: rtl/output_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : output_addr_counter
// Purpose  : (K+1)-bit result counter with synchronous clear, increment
//            enable and a terminal flag raised on the increment that moves
//            the count from M-1 to M.
// Revision : 1.0 - initial release
// ============================================================================
module output_addr_counter
  import outctrl_pkg::*;
#(
  parameter int M = C_M,
  parameter int K = C_K
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic [K:0] count,
  output logic       last
);

  localparam logic [K:0] C_LAST = (K + 1)'(M - 1);

  logic [K:0] r_count;

  // Count accepted results; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign last  = inc && (r_count == C_LAST);

endmodule : output_addr_counter
`default_nettype wire

// File: rtl/output_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : output_ram_ctrl
// Purpose  : Write sequencer for the output result RAM. Clears the RAM at
//            job start, writes M results to 1-based addresses 1..M from a
//            valid/ready stream, then pulses done after the last write.
// Options  : OUTCTRL_ERR_EN - adds a sticky err output flagging protocol
//            misuse (start or res_valid while the job cannot take them).
// Revision : 1.0 - initial release
// ============================================================================
module output_ram_ctrl
  import outctrl_pkg::*;
#(
  parameter int N = C_N,
  parameter int M = C_M,
  parameter int K = C_K
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           res_valid,
  output logic           res_ready,
  input  logic [2*N-1:0] result_in,
  output logic [2*N-1:0] result,
  output logic [K:0]     addr,
  output logic           outRAMen,
  output logic           clr,
  output logic           done,
`ifdef OUTCTRL_ERR_EN
  output logic           err,
`endif
  output logic           busy
);

  state_e         r_state;
  state_e         w_next;
  logic           w_accept;
  logic [K:0]     w_cnt;
  logic           w_last;
  logic [2*N-1:0] r_result;
  logic [K:0]     r_addr;
  logic           r_wr_en;

  // Handshake is decoded from the state register only, never from res_valid.
  assign res_ready = (r_state == ST_WRITE);
  assign w_accept  = res_valid && res_ready;

  output_addr_counter #(
    .M (M),
    .K (K)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (r_state == ST_CLEAR),
    .inc   (w_accept),
    .count (w_cnt),
    .last  (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; the accept that reaches M hands over to DRAIN so the
  // final write is still presented while done waits one more cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_WRITE;
      ST_WRITE: if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // RAM write port: one-cycle latency from accept; data/address hold
  // between accepts while the enable drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_addr   <= '0;
      r_wr_en  <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_result <= result_in;
        r_addr   <= w_cnt + 1'b1;
      end
    end
  end

  assign result   = r_result;
  assign addr     = r_addr;
  assign outRAMen = r_wr_en;
  assign clr      = (r_state == ST_CLEAR);
  assign done     = (r_state == ST_FIN);
  assign busy     = (r_state != ST_IDLE);

`ifdef OUTCTRL_ERR_EN
  logic r_err;

  // Sticky misuse flag; a new job (entry to CLEAR) starts it clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_next == ST_CLEAR) begin
      r_err <= 1'b0;
    end else if (busy && (start || (res_valid && (r_state != ST_WRITE)))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule : output_ram_ctrl
`default_nettype wire

// File: tb/tb_output_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_ram_ctrl
// Purpose  : Self-checking bench for output_ram_ctrl (default M=8 instance
//            plus an M=1 instance for the single-result corner case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, res_valid = 1'b0;
  logic [31:0] result_in = '0;
  logic        res_ready, outRAMen, clr, done, busy;
  logic [31:0] result;
  logic [3:0]  addr;

  logic        start1 = 1'b0, res_valid1 = 1'b0;
  logic [31:0] result_in1 = '0;
  logic        res_ready1, outRAMen1, clr1, done1, busy1;
  logic [31:0] result1;
  logic [3:0]  addr1;
`ifdef OUTCTRL_ERR_EN
  logic        err0, err1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_ram_ctrl #(.N(16), .M(8), .K(3)) dut (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid),
    .res_ready(res_ready), .result_in(result_in), .result(result),
    .addr(addr), .outRAMen(outRAMen), .clr(clr), .done(done),
`ifdef OUTCTRL_ERR_EN
    .err(err0),
`endif
    .busy(busy)
  );

  output_ram_ctrl #(.N(16), .M(1), .K(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .res_valid(res_valid1),
    .res_ready(res_ready1), .result_in(result_in1), .result(result1),
    .addr(addr1), .outRAMen(outRAMen1), .clr(clr1), .done(done1),
`ifdef OUTCTRL_ERR_EN
    .err(err1),
`endif
    .busy(busy1)
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] din;
    logic        e_clr;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [31:0] e_res;
    logic        e_done;
    logic        e_busy;
    logic        e_ready;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic s, logic v, logic [31:0] d, logic c,
                              logic we, logic [3:0] a, logic [31:0] r,
                              logic dn, logic b, logic rd);
    vec_t x;
    x.start = s; x.valid = v; x.din = d; x.e_clr = c; x.e_we = we;
    x.e_addr = a; x.e_res = r; x.e_done = dn; x.e_busy = b; x.e_ready = rd;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".res_ready"}, 32'(res_ready), 0);
    chk({tag, ".clr"},       32'(clr), 0);
    chk({tag, ".outRAMen"},  32'(outRAMen), 0);
    chk({tag, ".addr"},      32'(addr), 0);
    chk({tag, ".result"},    result, 0);
    chk({tag, ".done"},      32'(done), 0);
    chk({tag, ".busy"},      32'(busy), 0);
  endtask

  initial begin
    int acc, n_clr, n_done, n_we, n_clash;
    logic v;

    // Basic job: clear, 8 back-to-back writes, done two cycles after last accept.
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 8; k++)
      tbl[k+1] = mk(0, 1, 32'(k), 0, 1, 4'(k), 32'(k), 0, 1, (k < 8));
    tbl[10] = mk(0, 0, 0, 0, 0, 8, 8, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 8, 8, 0, 0, 0);

    // Reset state.
    rst = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Data presented while IDLE is dropped.
    res_valid = 1'b1; result_in = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle.res_ready", 32'(res_ready), 0);
      chk("idle.outRAMen", 32'(outRAMen), 0);
      chk("idle.busy", 32'(busy), 0);
    end
    res_valid = 1'b0;

    // Table-driven basic job.
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start; res_valid = tbl[i].valid; result_in = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d.clr", i),       32'(clr), 32'(tbl[i].e_clr));
      chk($sformatf("tbl%0d.outRAMen", i),  32'(outRAMen), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d.addr", i),      32'(addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.result", i),    result, tbl[i].e_res);
      chk($sformatf("tbl%0d.done", i),      32'(done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d.busy", i),      32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.res_ready", i), 32'(res_ready), 32'(tbl[i].e_ready));
    end
    start = 1'b0; res_valid = 1'b0;

    // Toggled res_valid: writes only after accepts, addresses contiguous.
    start = 1'b1; tick(); start = 1'b0;
    chk("tog.clr", 32'(clr), 1);
    tick();
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      v = (i % 2 == 0);
      res_valid = v; result_in = 32'h100 + 32'(i);
      tick();
      if (v && acc < 8) begin
        acc++;
        chk($sformatf("tog%0d.outRAMen", i), 32'(outRAMen), 1);
        chk($sformatf("tog%0d.addr", i), 32'(addr), 32'(acc));
        chk($sformatf("tog%0d.result", i), result, 32'h100 + 32'(i));
      end else begin
        chk($sformatf("tog%0d.outRAMen", i), 32'(outRAMen), 0);
      end
      chk($sformatf("tog%0d.done", i), 32'(done), 32'(i == 15));
      chk($sformatf("tog%0d.res_ready", i), 32'(res_ready), 32'(acc < 8));
    end
    res_valid = 1'b0;
    tick();
    chk("tog.busy_after", 32'(busy), 0);

    // start held high for a whole job: one clr, one done, eight writes.
    n_clr = 0; n_done = 0; n_we = 0; n_clash = 0;
    for (int i = 0; i < 11; i++) begin
      start = 1'b1; res_valid = 1'b1; result_in = 32'h200 + 32'(i);
      tick();
      n_clr += int'(clr); n_done += int'(done); n_we += int'(outRAMen);
      if ((clr && outRAMen) || (done && outRAMen)) n_clash++;
`ifdef OUTCTRL_ERR_EN
      if (i == 1) chk("hold.err", 32'(err0), 1);
`endif
    end
    start = 1'b0; res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_clr += int'(clr); n_done += int'(done); n_we += int'(outRAMen);
      if ((clr && outRAMen) || (done && outRAMen)) n_clash++;
    end
    chk("hold.clr_count", 32'(n_clr), 1);
    chk("hold.done_count", 32'(n_done), 1);
    chk("hold.we_count", 32'(n_we), 8);
    chk("hold.clash", 32'(n_clash), 0);
    chk("hold.busy_after", 32'(busy), 0);

    // Reset after 3 writes abandons the job; the next job restarts at addr 1.
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; result_in = 32'h300 + 32'(i);
      tick();
    end
    chk("mid.addr3", 32'(addr), 3);
    res_valid = 1'b0; rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_done += int'(done);
    end
    chk("midrst.no_done", 32'(n_done), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart.clr", 32'(clr), 1);
    tick();
    res_valid = 1'b1; result_in = 32'h400;
    tick();
    res_valid = 1'b0;
    chk("restart.outRAMen", 32'(outRAMen), 1);
    chk("restart.addr", 32'(addr), 1);
    chk("restart.result", result, 32'h400);

    // M=1 instance: single write to addr 1, done strictly after it.
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("m1.clr", 32'(clr1), 1);
    chk("m1.busy", 32'(busy1), 1);
    tick();
    chk("m1.res_ready", 32'(res_ready1), 1);
    res_valid1 = 1'b1; result_in1 = 32'hA5A50001;
    tick();
    res_valid1 = 1'b0;
    chk("m1.outRAMen", 32'(outRAMen1), 1);
    chk("m1.addr", 32'(addr1), 1);
    chk("m1.result", result1, 32'hA5A50001);
    chk("m1.done_early", 32'(done1), 0);
    chk("m1.ready_drain", 32'(res_ready1), 0);
    tick();
    chk("m1.done", 32'(done1), 1);
    chk("m1.outRAMen_fin", 32'(outRAMen1), 0);
    tick();
    chk("m1.done_end", 32'(done1), 0);
    chk("m1.busy_end", 32'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_output_ram_ctrl
`default_nettype wire
